// File: rtl/tx_arbiter.sv
// tx_arbiter: shares one rfd/dav_ serial transmitter among M producers through a one-word buffer.
// Define TXARB_FIXED_PRIO_EN for fixed priority (producer 0 highest); default build is round-robin.
module tx_arbiter #(
  parameter int N = 8,
  parameter int M = 4,
  parameter int W = 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [M*N-1:0] data_in,
  input  logic [M-1:0]   dav_,
  output logic [M-1:0]   rfd,
  output logic [N-1:0]   tx_data,
  output logic           tx_dav_,
  input  logic           tx_rfd,
  output logic [W-1:0]   grant_id,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    WAIT_RDY,
    OFFER
  } state_t;

  state_t         state_reg, state_next;
  logic [N-1:0]   buf_reg, buf_next;
  logic [N-1:0]   tx_data_reg, tx_data_next;
  logic [W-1:0]   sel_reg, sel_next;
  logic [W-1:0]   grant_reg, grant_next;
  logic [M-1:0]   rfd_reg, rfd_next;
  logic           tx_dav_reg, tx_dav_next;

  logic [M-1:0]   req;
  logic [N-1:0]   words [M];
  logic [W-1:0]   win_idx;
  logic           win_found;

  assign req = ~dav_;

  genvar gi;
  generate
    for (gi = 0; gi < M; gi++) begin : g_word
      assign words[gi] = data_in[gi*N +: N];
    end
  endgenerate

`ifdef TXARB_FIXED_PRIO_EN
  // Lowest-index requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < M; k++) begin
      if (!win_found && req[W'(k)]) begin
        win_found = 1'b1;
        win_idx   = W'(k);
      end
    end
  end
`else
  logic [W-1:0] last_reg;

  // Scan starts just after the last producer served and wraps at M-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= M; k++) begin
      if (!win_found && req[W'((int'(last_reg) + k) % M)]) begin
        win_found = 1'b1;
        win_idx   = W'((int'(last_reg) + k) % M);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_reg <= W'(M - 1);
    end else if (state_reg == OFFER && !tx_rfd) begin
      last_reg <= sel_reg;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      buf_reg     <= '0;
      tx_data_reg <= '0;
      sel_reg     <= '0;
      grant_reg   <= '0;
      rfd_reg     <= '1;
      tx_dav_reg  <= 1'b1;
    end else begin
      state_reg   <= state_next;
      buf_reg     <= buf_next;
      tx_data_reg <= tx_data_next;
      sel_reg     <= sel_next;
      grant_reg   <= grant_next;
      rfd_reg     <= rfd_next;
      tx_dav_reg  <= tx_dav_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    buf_next     = buf_reg;
    tx_data_next = tx_data_reg;
    sel_next     = sel_reg;
    grant_next   = grant_reg;
    rfd_next     = rfd_reg;
    tx_dav_next  = tx_dav_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          buf_next          = words[win_idx];
          sel_next          = win_idx;
          grant_next        = win_idx;
          rfd_next[win_idx] = 1'b0;
          state_next        = HOLD;
        end
      end
      HOLD: begin
        if (dav_[sel_reg]) begin
          state_next = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        // Only offer to an idle transmitter so a trailing frame cannot look like an accept.
        if (tx_rfd) begin
          tx_data_next = buf_reg;
          tx_dav_next  = 1'b0;
          state_next   = OFFER;
        end
      end
      OFFER: begin
        if (!tx_rfd) begin
          tx_dav_next       = 1'b1;
          rfd_next[sel_reg] = 1'b1;
          state_next        = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rfd      = rfd_reg;
  assign tx_data  = tx_data_reg;
  assign tx_dav_  = tx_dav_reg;
  assign grant_id = grant_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: directed scenarios plus randomized producers/transmitter,
// all checked every cycle against a transaction-level reference model.
module tb_tx_arbiter;
  localparam int N = 8;
  localparam int M = 4;
  localparam int W = 2;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [M*N-1:0] data_in = '0;
  logic [M-1:0]   dav_ = '1;
  logic           tx_rfd = 1'b1;
  logic [M-1:0]   rfd;
  logic [N-1:0]   tx_data;
  logic           tx_dav_;
  logic [W-1:0]   grant_id;
  logic           busy;

  always #5 clock = ~clock;

  tx_arbiter #(.N(N), .M(M), .W(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .data_in  (data_in),
    .dav_     (dav_),
    .rfd      (rfd),
    .tx_data  (tx_data),
    .tx_dav_  (tx_dav_),
    .tx_rfd   (tx_rfd),
    .grant_id (grant_id),
    .busy     (busy)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the buffer, and how far that word has travelled.
  int         m_owner = -1;
  int         m_last  = M - 1;
  int         m_grant = 0;
  logic [N-1:0] m_word   = '0;
  logic [N-1:0] m_txdata = '0;
  bit         m_released = 1'b0;
  bit         m_offered  = 1'b0;
  bit         m_valid    = 1'b0;

  function automatic int pick(input logic [M-1:0] r, input int last);
`ifdef TXARB_FIXED_PRIO_EN
    for (int i = 0; i < M; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= M; k++) if (r[(last + k) % M]) return (last + k) % M;
`endif
    return -1;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_owner = -1; m_last = M - 1; m_grant = 0; m_txdata = '0;
      m_released = 1'b0; m_offered = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_owner < 0) begin
        int w;
        w = pick(~dav_, m_last);
        if (w >= 0) begin
          m_owner = w; m_grant = w; m_word = data_in[w*N +: N];
          m_released = 1'b0; m_offered = 1'b0;
        end
      end else if (!m_released) begin
        if (dav_[m_owner]) m_released = 1'b1;
      end else if (!m_offered) begin
        if (tx_rfd) begin m_offered = 1'b1; m_txdata = m_word; end
      end else if (!tx_rfd) begin
        m_offered = 1'b0; m_last = m_owner; m_owner = -1;
      end
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clock) begin
    if (m_valid) begin
      logic [M-1:0] exp_rfd;
      exp_rfd = '1;
      if (m_owner >= 0) exp_rfd[m_owner] = 1'b0;
      check("rfd", 32'(rfd), 32'(exp_rfd));
      check("tx_dav_", 32'(tx_dav_), 32'(!m_offered));
      check("tx_data", 32'(tx_data), 32'(m_txdata));
      check("grant_id", 32'(grant_id), 32'(m_grant));
      check("busy", 32'(busy), 32'(m_owner >= 0));
    end
  end

  // Stimulus agents
  bit       auto_prod = 0, auto_tx = 0, rand_tx = 0, rand_data = 0;
  bit [M-1:0] prod_en = '0;
  int       hold_max = 0, frame_max = 0, frame_cnt = 0;
  int       hold_cnt [M];
  logic [N-1:0] acc_q [$];

  task automatic step();
    @(posedge clock);
    #1;
    if (auto_prod) begin
      for (int i = 0; i < M; i++) begin
        if (dav_[i] == 1'b0 && rfd[i] == 1'b0) begin
          if (hold_cnt[i] > 0) hold_cnt[i]--;
          else dav_[i] = 1'b1;
        end else if (dav_[i] == 1'b1 && rfd[i] == 1'b1 && prod_en[i]) begin
          data_in[i*N +: N] = rand_data ? N'($urandom) : N'(8'h10 + i);
          dav_[i] = 1'b0;
          hold_cnt[i] = int'($urandom_range(0, hold_max));
        end
      end
    end
    if (auto_tx) begin
      if (!tx_rfd) begin
        if (frame_cnt > 0) frame_cnt--;
        else tx_rfd = 1'b1;
      end else if (tx_dav_ == 1'b0) begin
        acc_q.push_back(tx_data);
        tx_rfd = 1'b0;
        frame_cnt = int'($urandom_range(0, frame_max));
      end else if (rand_tx && $urandom_range(0, 15) == 0) begin
        tx_rfd = 1'b0;
        frame_cnt = int'($urandom_range(0, frame_max));
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; auto_prod = 0; auto_tx = 0; rand_tx = 0;
    dav_ = '1; tx_rfd = 1'b1; frame_cnt = 0;
    for (int i = 0; i < M; i++) hold_cnt[i] = 0;
    step();
    step();
    reset = 1'b0;
  endtask

`ifdef TXARB_FIXED_PRIO_EN
  localparam logic [N-1:0] RR_EXP [5] = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10};
  localparam int SLOW_NEXT = 0;
`else
  localparam logic [N-1:0] RR_EXP [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
  localparam int SLOW_NEXT = 3;
`endif

  initial begin
    // Reset, no requests
    do_reset();
    for (int c = 0; c < 20; c++) begin
      step();
      check("idle_rfd", 32'(rfd), 32'hF);
      check("idle_txdav", 32'(tx_dav_), 32'h1);
      check("idle_busy", 32'(busy), 32'h0);
      check("idle_grant", 32'(grant_id), 32'h0);
    end

    // Single word from producer 2
    data_in[2*N +: N] = 8'hA5; dav_[2] = 1'b0;
    step();
    check("single_rfd", 32'(rfd), 32'hB);
    check("single_grant", 32'(grant_id), 32'h2);
    dav_[2] = 1'b1;
    step();
    step();
    check("single_offer_dav", 32'(tx_dav_), 32'h0);
    check("single_offer_data", 32'(tx_data), 32'hA5);
    tx_rfd = 1'b0;
    step();
    check("single_done_dav", 32'(tx_dav_), 32'h1);
    check("single_done_rfd", 32'(rfd), 32'hF);
    check("single_done_grant", 32'(grant_id), 32'h2);
    tx_rfd = 1'b1;

    // Fairness with all four producers requesting continuously
    do_reset();
    acc_q.delete();
    rand_data = 0; prod_en = '1; hold_max = 0; frame_max = 2;
    auto_prod = 1; auto_tx = 1;
    for (int c = 0; c < 400 && acc_q.size() < 5; c++) step();
    check("rr_count", 32'(acc_q.size() >= 5), 32'h1);
    if (acc_q.size() >= 5)
      for (int i = 0; i < 5; i++) check("rr_word", 32'(acc_q[i]), 32'(RR_EXP[i]));

    // Transmitter busy for 30 cycles after capture
    do_reset();
    tx_rfd = 1'b0;
    data_in[0 +: N] = 8'h5C; dav_[0] = 1'b0;
    step();
    dav_[0] = 1'b1;
    step();
    for (int c = 0; c < 30; c++) begin
      step();
      check("txbusy_dav", 32'(tx_dav_), 32'h1);
    end
    tx_rfd = 1'b1;
    step();
    check("txbusy_offer_dav", 32'(tx_dav_), 32'h0);
    check("txbusy_offer_data", 32'(tx_data), 32'h5C);
    tx_rfd = 1'b0;
    step();
    check("txbusy_done_dav", 32'(tx_dav_), 32'h1);
    check("txbusy_done_rfd", 32'(rfd), 32'hF);
    tx_rfd = 1'b1;

    // Slow producer 1 while 0 and 3 wait
    do_reset();
    data_in[1*N +: N] = 8'h3E; dav_[1] = 1'b0;
    step();
    check("slow_rfd", 32'(rfd), 32'hD);
    data_in[0 +: N] = 8'h40; data_in[3*N +: N] = 8'h43;
    dav_[0] = 1'b0; dav_[3] = 1'b0;
    for (int c = 0; c < 15; c++) begin
      step();
      check("slow_txdav", 32'(tx_dav_), 32'h1);
      check("slow_rfd03", 32'({rfd[3], rfd[0]}), 32'h3);
      check("slow_busy", 32'(busy), 32'h1);
    end
    dav_[1] = 1'b1;
    step();
    step();
    check("slow_offer_data", 32'(tx_data), 32'h3E);
    check("slow_offer_dav", 32'(tx_dav_), 32'h0);
    tx_rfd = 1'b0;
    step();
    tx_rfd = 1'b1;
    step();
    check("slow_next_grant", 32'(grant_id), 32'(SLOW_NEXT));

    // Reset in the middle of an offer
    do_reset();
    data_in[2*N +: N] = 8'h77; dav_[2] = 1'b0;
    step();
    dav_[2] = 1'b1;
    step();
    step();
    check("mid_offer_dav", 32'(tx_dav_), 32'h0);
    reset = 1'b1; dav_ = 4'b0100;
    step();
    check("mid_rst_dav", 32'(tx_dav_), 32'h1);
    check("mid_rst_rfd", 32'(rfd), 32'hF);
    check("mid_rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    step();
    check("mid_next_grant", 32'(grant_id), 32'h0);
    check("mid_next_rfd", 32'(rfd), 32'hE);

    // Randomized traffic with occasional resets
    do_reset();
    rand_data = 1; hold_max = 5; frame_max = 6;
    auto_prod = 1; auto_tx = 1; rand_tx = 1;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) prod_en = M'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end else begin
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
